mmcm_ps_sequencer: RTL and testbench

//  Sequences the MMCM dynamic phase-shift port (psen/psincdec/psdone) for the TDC calibration path.

---
 rtl/mmcm_ps_sequencer.sv | 159 +++++++++++++++
 tb/tb_mmcm_ps_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_ps_sequencer.sv
// MMCM dynamic phase-shift sequencer: turns relative step commands into psdone-gated psen pulses
// and tracks the absolute clk_ps phase modulo one output turn.
module mmcm_ps_sequencer #(
    parameter int STEP_W       = 16,
    parameter int PS_FULL_TURN = 448,
    parameter int POS_W        = 9,
    parameter int MIN_GAP      = 2,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic              psclk,
    input  logic              reset,
    input  logic              locked,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_incr,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              psen,
    output logic              psincdec,
    input  logic              psdone,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  phase_pos,
    output logic              err_timeout,
    output logic              err_unlock,
    input  logic              err_clr
);

    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(PS_FULL_TURN - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP,
        ERROR
    } state_t;

    state_t            state;
    logic [STEP_W-1:0] remaining;
    logic [TO_W-1:0]   to_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    always_ff @(posedge psclk) begin
        if (reset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            psen        <= 1'b0;
            psincdec    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            phase_pos   <= '0;
            err_timeout <= 1'b0;
            err_unlock  <= 1'b0;
            remaining   <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            done <= 1'b0;
            psen <= 1'b0;

            if (!locked && (state == ISSUE || state == WAIT_DONE || state == GAP)) begin
                err_unlock <= 1'b1;
                busy       <= 1'b0;
                cmd_ready  <= 1'b0;
                state      <= ERROR;
            end else begin
                case (state)
                    IDLE: begin
                        cmd_ready <= locked & ~err_timeout & ~err_unlock;
                        if (cmd_valid && cmd_ready) begin
                            remaining <= cmd_steps;
                            psincdec  <= cmd_incr;
                            if (cmd_steps == '0) begin
                                done <= 1'b1;
                            end else if (!locked) begin
                                // lock lost on the accept edge: fail before any psen goes out
                                err_unlock <= 1'b1;
                                cmd_ready  <= 1'b0;
                                state      <= ERROR;
                            end else begin
                                psen      <= 1'b1;
                                busy      <= 1'b1;
                                cmd_ready <= 1'b0;
                                to_cnt    <= '0;
                                state     <= ISSUE;
                            end
                        end
                    end

                    ISSUE: begin
                        to_cnt <= to_cnt + 1'b1;
                        state  <= WAIT_DONE;
                    end

                    WAIT_DONE: begin
                        if (psdone) begin
                            if (psincdec)
                                phase_pos <= (phase_pos == POS_MAX) ? '0 : phase_pos + 1'b1;
                            else
                                phase_pos <= (phase_pos == '0) ? POS_MAX : phase_pos - 1'b1;
                            remaining <= remaining - 1'b1;
                            if (remaining == STEP_W'(1)) begin
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                cmd_ready <= 1'b1;
                                state     <= IDLE;
                            end else if (MIN_GAP == 0) begin
                                psen   <= 1'b1;
                                to_cnt <= '0;
                                state  <= ISSUE;
                            end else begin
                                gap_cnt <= GAP_INIT;
                                state   <= GAP;
                            end
                        end else if (to_cnt >= TO_LIMIT) begin
                            err_timeout <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ERROR;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end

                    GAP: begin
                        if (gap_cnt == '0) begin
                            psen   <= 1'b1;
                            to_cnt <= '0;
                            state  <= ISSUE;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end

                    ERROR: begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b0;
                        if (err_clr) begin
                            err_timeout <= 1'b0;
                            err_unlock  <= 1'b0;
                            cmd_ready   <= locked;
                            state       <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end

            // a relock puts the MMCM back at its static phase
            if (!locked)
                phase_pos <= '0;
        end
    end

endmodule

// File: tb/tb_mmcm_ps_sequencer.sv
// Self-checking bench for mmcm_ps_sequencer: behavioural MMCM psdone responder plus a scoreboard
// of expected final positions and pulse counts per command.
module tb_mmcm_ps_sequencer;

    localparam int TURN = 448;

    logic        psclk = 1'b0;
    logic        reset, locked, cmd_valid, cmd_incr, err_clr;
    logic [15:0] cmd_steps;
    logic        cmd_ready, psen, psincdec, psdone, busy, done, err_timeout, err_unlock;
    logic [8:0]  phase_pos;

    mmcm_ps_sequencer #(
        .STEP_W(16), .PS_FULL_TURN(448), .POS_W(9), .MIN_GAP(2), .TIMEOUT_CYC(64)
    ) dut (
        .psclk(psclk), .reset(reset), .locked(locked),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_incr(cmd_incr), .cmd_steps(cmd_steps),
        .psen(psen), .psincdec(psincdec), .psdone(psdone),
        .busy(busy), .done(done), .phase_pos(phase_pos),
        .err_timeout(err_timeout), .err_unlock(err_unlock), .err_clr(err_clr)
    );

    always #5 psclk = ~psclk;

    typedef struct {
        logic [8:0] pos;
        int         steps;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int model_pos = 0;
    int cmd_base = 0;

    // MMCM model, evaluated on the falling edge
    logic model_done = 1'b0;
    logic spur_done  = 1'b0;
    assign psdone = model_done | spur_done;
    int   psdone_delay = 5;
    int   withhold_from = 0;
    logic exp_dir = 1'b0;
    int   psen_cnt = 0, dir_bad = 0, gap_bad = 0, cyc = 0, done_cyc = -1, psen_cyc = 0, pend = 0;
    bit   cmd_boundary = 1'b1;

    always @(negedge psclk) begin
        cyc = cyc + 1;
        model_done = 1'b0;
        if (done || !busy || reset) cmd_boundary = 1'b1;
        if (psen) begin
            psen_cnt = psen_cnt + 1;
            psen_cyc = cyc;
            if (psincdec !== exp_dir) dir_bad = dir_bad + 1;
            if (!cmd_boundary && (cyc - done_cyc != 3)) gap_bad = gap_bad + 1;
            cmd_boundary = 1'b0;
            pend = psdone_delay;
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0 && !(withhold_from != 0 && psen_cnt >= withhold_from)) begin
                model_done = 1'b1;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge psclk);
        #1;
    endtask

    task automatic send_cmd(input logic incr, input int steps, input bit push);
        bit   ok = 1'b0;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_incr  = incr;
        cmd_steps = 16'(steps);
        exp_dir   = incr;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) $display("FAIL accept_wait: cmd_ready=%b required 1 within 200 cycles", cmd_ready);
        else passed++;
        tick();
        cmd_valid = 1'b0;
        cmd_base  = psen_cnt;
        if (incr) model_pos = (model_pos + steps) % TURN;
        else      model_pos = (model_pos + TURN - (steps % TURN)) % TURN;
        if (push) begin
            e.pos   = 9'(model_pos);
            e.steps = steps;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < budget; i++) begin
            @(negedge psclk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) $display("FAIL done_wait: no done pulse within %0d cycles", budget);
        else passed++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (phase_pos !== e.pos)
                $display("FAIL sb_phase_pos: got %0d required %0d", phase_pos, e.pos);
            else passed++;
            checks++;
            if (psen_cnt - cmd_base !== e.steps)
                $display("FAIL sb_psen_count: got %0d required %0d", psen_cnt - cmd_base, e.steps);
            else passed++;
            checks++;
            if (busy !== 1'b0) $display("FAIL sb_busy_at_done: got %b required 0", busy);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; locked = 1'b1; cmd_valid = 1'b0; cmd_incr = 1'b0; cmd_steps = '0; err_clr = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, psen, psincdec, busy, done, err_timeout, err_unlock, phase_pos} !== '0)
            $display("FAIL reset_values: got %b_%0d required all zero",
                     {cmd_ready, psen, psincdec, busy, done, err_timeout, err_unlock}, phase_pos);
        else passed++;
        reset = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", cmd_ready);
        else passed++;
    endtask

    task automatic test_incr3();
        psdone_delay = 5;
        send_cmd(1'b1, 3, 1'b1);
        checks++;
        if ({busy, psen} !== 2'b11) $display("FAIL first_psen: busy,psen=%b required 11", {busy, psen});
        else passed++;
        wait_done(200);
        tick();
        checks++;
        if (done !== 1'b0) $display("FAIL single_done: done=%b required 0", done);
        else passed++;
        checks++;
        if (gap_bad !== 0 || dir_bad !== 0)
            $display("FAIL gap_and_dir: gap_bad=%0d dir_bad=%0d required 0/0", gap_bad, dir_bad);
        else passed++;
    endtask

    task automatic test_wrap();
        psdone_delay = 1;
        send_cmd(1'b0, 3, 1'b1);
        wait_done(200);
        send_cmd(1'b0, 1, 1'b1);
        wait_done(200);
        send_cmd(1'b1, 449, 1'b1);
        wait_done(4000);
        checks++;
        if (gap_bad !== 0 || dir_bad !== 0)
            $display("FAIL wrap_gap_dir: gap_bad=%0d dir_bad=%0d required 0/0", gap_bad, dir_bad);
        else passed++;
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        psdone_delay = 2;
        withhold_from = psen_cnt + 2;
        send_cmd(1'b1, 3, 1'b0);
        model_pos = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (err_timeout === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || cyc - psen_cyc != 64)
            $display("FAIL timeout_latency: err_timeout=%b cycles=%0d required 1/64",
                     err_timeout, cyc - psen_cyc);
        else passed++;
        repeat (20) tick();
        checks++;
        if (psen_cnt - cmd_base !== 2 || phase_pos !== 9'd1 || busy !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL timeout_state: psen=%0d pos=%0d busy=%b ready=%b required 2/1/0/0",
                     psen_cnt - cmd_base, phase_pos, busy, cmd_ready);
        else passed++;
        withhold_from = 0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL timeout_clear: err=%b ready=%b required 0/1", err_timeout, cmd_ready);
        else passed++;
    endtask

    task automatic test_unlock();
        bit seen = 1'b0;
        psdone_delay = 5;
        send_cmd(1'b1, 5, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (psen_cnt - cmd_base == 2) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        locked = 1'b0;
        tick();
        checks++;
        if (!seen || err_unlock !== 1'b1 || phase_pos !== 9'd0 || psen !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL unlock_entry: seen=%b err=%b pos=%0d psen=%b ready=%b busy=%b required 1/1/0/0/0/0",
                     seen, err_unlock, phase_pos, psen, cmd_ready, busy);
        else passed++;
        repeat (10) tick();
        checks++;
        if (psen_cnt - cmd_base !== 2 || cmd_ready !== 1'b0)
            $display("FAIL unlock_hold: psen=%0d ready=%b required 2/0", psen_cnt - cmd_base, cmd_ready);
        else passed++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_unlock !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL unlock_clear_unlocked: err=%b ready=%b required 0/0", err_unlock, cmd_ready);
        else passed++;
        locked = 1'b1;
        model_pos = 0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL relock_ready: got %b required 1", cmd_ready);
        else passed++;
    endtask

    task automatic test_zero_and_spurious();
        psdone_delay = 2;
        send_cmd(1'b1, 2, 1'b1);
        wait_done(200);
        tick();
        send_cmd(1'b1, 0, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || psen !== 1'b0)
            $display("FAIL zero_steps: done=%b busy=%b psen=%b required 1/0/0", done, busy, psen);
        else passed++;
        repeat (3) tick();
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        tick();
        checks++;
        if (phase_pos !== 9'(model_pos) || psen_cnt !== cmd_base || err_timeout !== 1'b0 || err_unlock !== 1'b0)
            $display("FAIL spurious_psdone: pos=%0d psen=%0d errs=%b%b required %0d/%0d/00",
                     phase_pos, psen_cnt, err_timeout, err_unlock, model_pos, cmd_base);
        else passed++;
    endtask

    task automatic test_reset_in_gap();
        int base2;
        bit seen = 1'b0;
        psdone_delay = 2;
        send_cmd(1'b1, 3, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (model_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        reset = 1'b1; locked = 1'b0;
        cmd_valid = 1'b1; cmd_incr = 1'b1; cmd_steps = 16'd1;
        tick();
        checks++;
        if (!seen || {cmd_ready, psen, psincdec, busy, done, err_timeout, err_unlock, phase_pos} !== '0)
            $display("FAIL reset_in_gap: seen=%b outputs=%b_%0d required 1 and all zero", seen,
                     {cmd_ready, psen, psincdec, busy, done, err_timeout, err_unlock}, phase_pos);
        else passed++;
        base2 = psen_cnt;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b0 || psen_cnt !== base2)
            $display("FAIL held_valid_unlocked: busy=%b ready=%b psen=%0d required 0/0/%0d",
                     busy, cmd_ready, psen_cnt, base2);
        else passed++;
        locked = 1'b1;
        model_pos = 0;
        send_cmd(1'b1, 1, 1'b1);
        wait_done(200);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_incr3();
        test_wrap();
        test_timeout();
        test_unlock();
        test_zero_and_spurious();
        test_reset_in_gap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
